// File: rtl/lvt_multiport_ram.sv
// Multi-port RAM: R read ports and W write ports built from W x R 1W1R banks.
// A per-byte live value table records which write port's bank holds the current
// copy of each byte, so masked writes from different ports merge correctly.
// Bank contents and the table are initialised by a counter sweep after reset.
module lvt_multiport_ram #(
  parameter int RAM_WIDTH         = 64,
  parameter int RAM_DEPTH         = 128,
  parameter int NUM_OF_READ_PORT  = 2,
  parameter int NUM_OF_WRITE_PORT = 2,
  parameter int OUTPUT_REG        = 0,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                                clock,
  input  logic                                reset_n,
  output logic                                init_busy,
  input  logic                                r_en      [NUM_OF_READ_PORT],
  input  logic [$clog2(RAM_DEPTH)-1:0]        r_ram_idx [NUM_OF_READ_PORT],
  output logic                                r_valid   [NUM_OF_READ_PORT],
  output logic [RAM_WIDTH-1:0]                r_data    [NUM_OF_READ_PORT],
  input  logic                                w_en      [NUM_OF_WRITE_PORT],
  input  logic [$clog2(RAM_DEPTH)-1:0]        w_ram_idx [NUM_OF_WRITE_PORT],
  input  logic [RAM_WIDTH-1:0]                w_data    [NUM_OF_WRITE_PORT],
  input  logic [RAM_WIDTH/8-1:0]              w_mask    [NUM_OF_WRITE_PORT]
);
  localparam int BYTES = RAM_WIDTH / 8;
  localparam int IDX   = $clog2(RAM_DEPTH);
  localparam int R     = NUM_OF_READ_PORT;
  localparam int W     = NUM_OF_WRITE_PORT;
  localparam int CW    = (W == 1) ? 1 : $clog2(W);

  typedef enum logic {INIT, READY} state_t;

  state_t           state, state_nxt;
  logic [IDX-1:0]   init_cnt;
  logic             ready;
  logic [BYTES-1:0] we [W];
  logic [CW-1:0]    lvt [RAM_DEPTH][BYTES];

  logic [CW-1:0]        sel_p0      [R][BYTES];
  logic [BYTES-1:0]     byp_p0      [R];
  logic [RAM_WIDTH-1:0] byp_data_p0 [R];

  logic                 vld_p1      [R];
  logic [CW-1:0]        sel_p1      [R][BYTES];
  logic [BYTES-1:0]     byp_p1      [R];
  logic [RAM_WIDTH-1:0] byp_data_p1 [R];
  logic [RAM_WIDTH-1:0] bank_q      [W][R];
  logic [RAM_WIDTH-1:0] data_p1     [R];

  // State register and init sweep address counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + IDX'(1);
    end
  end

  // Next state: leave INIT on the edge that clears the last address
  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    ready     = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        if (init_cnt == IDX'(RAM_DEPTH - 1)) state_nxt = READY;
      end
      READY:   ready = 1'b1;
      default: state_nxt = INIT;
    endcase
  end

  // Per-port byte write enables; all requests are dropped during init
  always_comb begin
    for (int w = 0; w < W; w++) we[w] = (ready && w_en[w]) ? w_mask[w] : '0;
  end

  // Live value table: ascending port order lets the highest port win a byte
  always_ff @(posedge clock) begin
    if (init_busy) begin
      for (int b = 0; b < BYTES; b++) lvt[init_cnt][b] <= '0;
    end else begin
      for (int w = 0; w < W; w++)
        for (int b = 0; b < BYTES; b++)
          if (we[w][b]) lvt[w_ram_idx[w]][b] <= CW'(w);
    end
  end

  // Request stage: LVT lookup plus same-cycle write bypass per byte
  always_comb begin
    for (int r = 0; r < R; r++) begin
      byp_p0[r]      = '0;
      byp_data_p0[r] = '0;
      for (int b = 0; b < BYTES; b++) begin
        sel_p0[r][b] = lvt[r_ram_idx[r]][b];
        for (int w = 0; w < W; w++) begin
          if (we[w][b] && (w_ram_idx[w] == r_ram_idx[r])) begin
            byp_p0[r][b]              = 1'b1;
            byp_data_p0[r][8*b +: 8]  = w_data[w][8*b +: 8];
            sel_p0[r][b]              = CW'(w);
          end
        end
      end
    end
  end

  // Bank array: bank[w][r] is written only by port w and read only by port r
  for (genvar gw = 0; gw < W; gw++) begin : g_wr
    for (genvar gr = 0; gr < R; gr++) begin : g_rd
      logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

      // One write port (init sweep or masked write), one registered read port
      always_ff @(posedge clock) begin
        if (init_busy) begin
          mem[init_cnt] <= INIT_VALUE;
        end else begin
          for (int b = 0; b < BYTES; b++)
            if (we[gw][b]) mem[w_ram_idx[gw]][8*b +: 8] <= w_data[gw][8*b +: 8];
        end
        if (ready && r_en[gr]) bank_q[gw][gr] <= mem[r_ram_idx[gr]];
      end
    end
  end

  // ---- stage p1: read valid (control, reset) ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < R; r++) vld_p1[r] <= 1'b0;
    end else begin
      for (int r = 0; r < R; r++) vld_p1[r] <= ready && r_en[r];
    end
  end

  // ---- stage p1: byte source selects and bypass bytes (data, no reset) ----
  always_ff @(posedge clock) begin
    for (int r = 0; r < R; r++) begin
      if (ready && r_en[r]) begin
        for (int b = 0; b < BYTES; b++) sel_p1[r][b] <= sel_p0[r][b];
        byp_p1[r]      <= byp_p0[r];
        byp_data_p1[r] <= byp_data_p0[r];
      end
    end
  end

  // Byte-wise merge of bank outputs; zero whenever the slot is not valid
  always_comb begin
    for (int r = 0; r < R; r++) begin
      data_p1[r] = '0;
      for (int b = 0; b < BYTES; b++) begin
        for (int w = 0; w < W; w++)
          if (sel_p1[r][b] == CW'(w)) data_p1[r][8*b +: 8] = bank_q[w][r][8*b +: 8];
        if (byp_p1[r][b]) data_p1[r][8*b +: 8] = byp_data_p1[r][8*b +: 8];
      end
      if (!vld_p1[r]) data_p1[r] = '0;
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                 vld_p2  [R];
    logic [RAM_WIDTH-1:0] data_p2 [R];

    // ---- stage p2: optional output register ----
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int r = 0; r < R; r++) begin
          vld_p2[r]  <= 1'b0;
          data_p2[r] <= '0;
        end
      end else begin
        for (int r = 0; r < R; r++) begin
          vld_p2[r]  <= vld_p1[r];
          data_p2[r] <= data_p1[r];
        end
      end
    end

    // Drive ports from the output register
    always_comb begin
      for (int r = 0; r < R; r++) begin
        r_valid[r] = vld_p2[r];
        r_data[r]  = data_p2[r];
      end
    end
  end else begin : g_nreg
    // Drive ports straight from the merge stage
    always_comb begin
      for (int r = 0; r < R; r++) begin
        r_valid[r] = vld_p1[r];
        r_data[r]  = data_p1[r];
      end
    end
  end

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Bench for lvt_multiport_ram: two instances (OUTPUT_REG=0 and 1) share stimulus;
// a byte-array reference model feeds per-port expectation queues that a
// negedge monitor drains whenever r_valid is seen.
module tb_lvt_multiport_ram;
  logic        clock;
  logic        reset_n;
  logic        busy0, busy1;
  logic        r_en      [2];
  logic [6:0]  r_ram_idx [2];
  logic        rv0 [2], rv1 [2];
  logic [63:0] rd0 [2], rd1 [2];
  logic        w_en      [2];
  logic [6:0]  w_ram_idx [2];
  logic [63:0] w_data    [2];
  logic [7:0]  w_mask    [2];

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  exp_t        sb [2][2][$];
  logic [63:0] model_mem [128];
  bit          model_ready;
  int          cyc;
  int          checks;
  int          errors;

  lvt_multiport_ram #(
    .RAM_WIDTH(64), .RAM_DEPTH(128), .NUM_OF_READ_PORT(2), .NUM_OF_WRITE_PORT(2),
    .OUTPUT_REG(0), .INIT_VALUE(64'h0)
  ) u_ram0 (
    .clock(clock), .reset_n(reset_n), .init_busy(busy0),
    .r_en(r_en), .r_ram_idx(r_ram_idx), .r_valid(rv0), .r_data(rd0),
    .w_en(w_en), .w_ram_idx(w_ram_idx), .w_data(w_data), .w_mask(w_mask)
  );

  lvt_multiport_ram #(
    .RAM_WIDTH(64), .RAM_DEPTH(128), .NUM_OF_READ_PORT(2), .NUM_OF_WRITE_PORT(2),
    .OUTPUT_REG(1), .INIT_VALUE(64'h0)
  ) u_ram1 (
    .clock(clock), .reset_n(reset_n), .init_busy(busy1),
    .r_en(r_en), .r_ram_idx(r_ram_idx), .r_valid(rv1), .r_data(rd1),
    .w_en(w_en), .w_ram_idx(w_ram_idx), .w_data(w_data), .w_mask(w_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever an instance presents r_valid
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        logic        v;
        logic [63:0] dat;
        exp_t        e;
        v   = (d == 0) ? rv0[p] : rv1[p];
        dat = (d == 0) ? rd0[p] : rd1[p];
        if (v === 1'b1) begin
          if (sb[d][p].size() == 0) begin
            chk($sformatf("unexpected_valid_reg%0d_port%0d", d, p), 64'd1, 64'd0);
          end else begin
            e = sb[d][p].pop_front();
            chk($sformatf("latency_reg%0d_port%0d", d, p), 64'(cyc), 64'(e.due));
            chk($sformatf("data_reg%0d_port%0d", d, p), dat, e.data);
          end
        end else begin
          chk($sformatf("idle_data_reg%0d_port%0d", d, p), dat, 64'd0);
          if (sb[d][p].size() > 0 && sb[d][p][0].due <= cyc) begin
            e = sb[d][p].pop_front();
            chk($sformatf("missing_valid_reg%0d_port%0d", d, p), {63'd0, v}, 64'd1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    for (int i = 0; i < 2; i++) begin
      r_en[i] = 1'b0; r_ram_idx[i] = '0;
      w_en[i] = 1'b0; w_ram_idx[i] = '0; w_data[i] = '0; w_mask[i] = '0;
    end
  endtask

  function automatic logic [6:0] pick_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return 7'd0;
    if (s == 1) return 7'd127;
    if (s == 2) return 7'($urandom_range(0, 127));
    return 7'($urandom_range(0, 7));
  endfunction

  task automatic set_random();
    for (int i = 0; i < 2; i++) begin
      w_en[i]      = 1'($urandom_range(0, 1));
      w_ram_idx[i] = pick_addr();
      w_data[i]    = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       w_mask[i] = 8'hFF;
        1:       w_mask[i] = 8'h00;
        default: w_mask[i] = 8'($urandom_range(0, 255));
      endcase
      r_en[i]      = 1'($urandom_range(0, 1));
      r_ram_idx[i] = pick_addr();
    end
  endtask

  // Apply this cycle's writes to the model, then queue the read results.
  // A read sees every write of its own cycle (bypass), highest port last.
  task automatic commit(input bit use_x = 1'b0, input logic [63:0] x0 = '0,
                        input logic [63:0] x1 = '0);
    exp_t e;
    if (!model_ready) return;
    for (int w = 0; w < 2; w++)
      if (w_en[w])
        for (int b = 0; b < 8; b++)
          if (w_mask[w][b]) model_mem[w_ram_idx[w]][8*b +: 8] = w_data[w][8*b +: 8];
    for (int r = 0; r < 2; r++) begin
      if (r_en[r]) begin
        e.data = use_x ? ((r == 0) ? x0 : x1) : model_mem[r_ram_idx[r]];
        e.due  = cyc + 1;
        sb[0][r].push_back(e);
        e.due  = cyc + 2;
        sb[1][r].push_back(e);
      end
    end
  endtask

  // Count edges until init_busy drops, issuing ignored garbage meanwhile
  task automatic init_wait();
    int n;
    n = 0;
    for (int a = 0; a < 128; a++) model_mem[a] = 64'h0;
    repeat (200) begin
      tick();
      n++;
      if (busy0 !== 1'b1) break;
      set_random();
    end
    chk("init_edges", 64'(n), 64'd128);
    chk("init_busy_reg1", {63'd0, busy1}, 64'd0);
    set_idle();
    model_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; checks = 0; errors = 0; model_ready = 1'b0;
    reset_n = 1'b0;
    set_idle();
    #1;
    chk("reset_busy_reg0", {63'd0, busy0}, 64'd1);
    chk("reset_busy_reg1", {63'd0, busy1}, 64'd1);
    chk("reset_valid_reg0", {62'd0, rv0[0], rv0[1]}, 64'd0);
    chk("reset_valid_reg1", {62'd0, rv1[0], rv1[1]}, 64'd0);
    #22 reset_n = 1'b1;
    init_wait();

    // first READY edge: read addr 5, plus boundary addresses
    r_en[1] = 1'b1; r_ram_idx[1] = 7'd5; commit(1'b1, '0, '0);
    tick(); set_idle();
    r_en[0] = 1'b1; r_ram_idx[0] = 7'd0; r_en[1] = 1'b1; r_ram_idx[1] = 7'd127;
    commit(1'b1, '0, '0);

    // basic write then read
    tick(); set_idle();
    w_en[1] = 1'b1; w_ram_idx[1] = 7'd3; w_data[1] = 64'h1122334455667788; w_mask[1] = 8'hFF;
    commit();
    tick(); set_idle();
    r_en[0] = 1'b1; r_ram_idx[0] = 7'd3; commit(1'b1, 64'h1122334455667788, '0);

    // cross-port partial merge
    tick(); set_idle();
    w_en[0] = 1'b1; w_ram_idx[0] = 7'd7; w_data[0] = 64'hAAAAAAAAAAAAAAAA; w_mask[0] = 8'hFF;
    commit();
    tick(); set_idle();
    w_en[1] = 1'b1; w_ram_idx[1] = 7'd7; w_data[1] = 64'h00000000000000BB; w_mask[1] = 8'h01;
    commit();
    tick(); set_idle();
    r_en[0] = 1'b1; r_ram_idx[0] = 7'd7; r_en[1] = 1'b1; r_ram_idx[1] = 7'd7;
    commit(1'b1, 64'hAAAAAAAAAAAAAABB, 64'hAAAAAAAAAAAAAABB);

    // same-cycle collision with bypass, then later re-read
    tick(); set_idle();
    w_en[0] = 1'b1; w_ram_idx[0] = 7'd9; w_data[0] = 64'h1111111111111111; w_mask[0] = 8'hFF;
    w_en[1] = 1'b1; w_ram_idx[1] = 7'd9; w_data[1] = 64'h2222222222222222; w_mask[1] = 8'h0F;
    r_en[0] = 1'b1; r_ram_idx[0] = 7'd9;
    commit(1'b1, 64'h1111111122222222, '0);
    tick(); set_idle();
    tick();
    r_en[0] = 1'b1; r_ram_idx[0] = 7'd9; r_en[1] = 1'b1; r_ram_idx[1] = 7'd9;
    commit(1'b1, 64'h1111111122222222, 64'h1111111122222222);

    // single pulsed read of addr 3, then quiet cycles
    tick(); set_idle();
    r_en[1] = 1'b1; r_ram_idx[1] = 7'd3; commit(1'b1, '0, 64'h1122334455667788);
    tick(); set_idle();
    repeat (4) tick();

    // randomized traffic against the model
    repeat (400) begin
      tick();
      set_random();
      commit();
    end

    // reset mid-operation while writing addr 3
    tick(); set_idle();
    for (int i = 0; i < 2; i++) begin
      w_en[i] = 1'b1; w_ram_idx[i] = 7'd3; w_data[i] = {$urandom, $urandom}; w_mask[i] = 8'hFF;
      r_en[i] = 1'b1; r_ram_idx[i] = 7'd3;
    end
    commit();
    tick();
    commit();
    #2;
    reset_n = 1'b0;
    model_ready = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) sb[d][p].delete();
    #1;
    chk("midreset_busy_reg0", {63'd0, busy0}, 64'd1);
    chk("midreset_busy_reg1", {63'd0, busy1}, 64'd1);
    chk("midreset_valid_reg0", {62'd0, rv0[0], rv0[1]}, 64'd0);
    chk("midreset_valid_reg1", {62'd0, rv1[0], rv1[1]}, 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1 reset_n = 1'b1;
    init_wait();

    // contents lost: addr 3 and addr 9 read back as the init value
    r_en[0] = 1'b1; r_ram_idx[0] = 7'd3; r_en[1] = 1'b1; r_ram_idx[1] = 7'd9;
    commit(1'b1, '0, '0);
    repeat (60) begin
      tick();
      set_random();
      commit();
    end

    tick(); set_idle();
    repeat (5) tick();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        chk($sformatf("drained_reg%0d_port%0d", d, p), 64'(sb[d][p].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
